// File: rtl/python_stream_gen_10bit_pkg.sv
// Shared PYTHON link definitions: 10-bit sync codes, generator states and
// test-pattern selects, used by the transmit generator, aligner and checker.
package python_pkg;

   localparam logic [9:0] SYNC_TR    = 10'h3A6;
   localparam logic [9:0] SYNC_FS    = 10'h2AA;
   localparam logic [9:0] SYNC_FE    = 10'h3AA;
   localparam logic [9:0] SYNC_LS    = 10'h0AA;
   localparam logic [9:0] SYNC_LE    = 10'h12A;
   localparam logic [9:0] SYNC_IMG   = 10'h035;
   localparam logic [9:0] SYNC_BL    = 10'h015;
   localparam logic [9:0] TRAIN_WORD = 10'h3A6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LINE   = 2'd1,
      ST_HBLANK = 2'd2,
      ST_VBLANK = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      PAT_RAMP    = 2'd0,
      PAT_FIXED   = 2'd1,
      PAT_CHAN_ID = 2'd2,
      PAT_WALK    = 2'd3
   } pattern_e;

   // First column wins over last column; width is clamped so they never coincide.
   function automatic logic [9:0] line_sync_code(
      input logic first_col,
      input logic last_col,
      input logic first_line,
      input logic last_line
   );
      logic [9:0] code;
      if (first_col) begin
         code = first_line ? SYNC_FS : SYNC_LS;
      end else if (last_col) begin
         code = last_line ? SYNC_FE : SYNC_LE;
      end else begin
         code = SYNC_IMG;
      end
      return code;
   endfunction

endpackage

// File: rtl/python_stream_gen_10bit_if.sv
// Configuration and word-stream bundle of the PYTHON stream generator.
// master = generator side, slave = controller / receiver side.
interface python_stream_gen_10bit_if #(
   parameter int CHANNELS = 4,
   parameter int X_BITS   = 10,
   parameter int Y_BITS   = 10,
   parameter int B_BITS   = 8
);
   logic                     enable;
   logic [X_BITS-1:0]        width;
   logic [Y_BITS-1:0]        height;
   logic [B_BITS-1:0]        h_blank;
   logic [B_BITS-1:0]        v_blank;
   logic [1:0]               pattern;
   logic [9:0]               fixed_value;
   logic [CHANNELS*10-1:0]   out_data;
   logic [9:0]               out_sync;
   logic                     out_frame_start;
   logic                     busy;

   modport master (
      input  enable, width, height, h_blank, v_blank, pattern, fixed_value,
      output out_data, out_sync, out_frame_start, busy
   );

   modport slave (
      output enable, width, height, h_blank, v_blank, pattern, fixed_value,
      input  out_data, out_sync, out_frame_start, busy
   );
endinterface

// File: rtl/python_stream_gen_10bit_pattern.sv
// Combinational test-pattern word for one data channel at column x, line y.
module python_tx_pattern
   import python_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int X_BITS   = 10,
   parameter int Y_BITS   = 10
)
(
   input  pattern_e          pattern,
   input  logic [X_BITS-1:0] x,
   input  logic [Y_BITS-1:0] y,
   input  logic [9:0]        channel,
   input  logic [9:0]        fixed_value,
   output logic [9:0]        word
);

   logic [9:0]  x_lo_s;
   logic [9:0]  y_lo_s;
   logic [31:0] walk_idx_s;

   // Ramp arithmetic is mod 1024, so only the low 10 bits of x and y matter;
   // the walking-one index needs the full column value.
   always_comb begin
      x_lo_s     = 10'(x);
      y_lo_s     = 10'(y);
      walk_idx_s = (32'(x) + 32'(channel)) % 32'd10;
      case (pattern)
         PAT_RAMP:    word = x_lo_s * 10'(CHANNELS) + channel + y_lo_s;
         PAT_FIXED:   word = fixed_value;
         PAT_CHAN_ID: word = channel;
         PAT_WALK:    word = 10'd1 << walk_idx_s;
         default:     word = 10'h000;
      endcase
   end

endmodule

// File: rtl/python_stream_gen_10bit.sv
// PYTHON300-style frame generator: sync channel plus CHANNELS data channels of
// 10-bit words, registered, ahead of the 10:1 serializers.
module python_stream_gen_10bit
   import python_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int X_BITS   = 10,
   parameter int Y_BITS   = 10,
   parameter int B_BITS   = 8
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cke,
   python_stream_gen_10bit_if.master bus
);

   state_e                 state_r,  state_next_s;
   logic [X_BITS-1:0]      x_r,      x_next_s;
   logic [Y_BITS-1:0]      y_r,      y_next_s;
   logic [B_BITS-1:0]      cnt_r,    cnt_next_s;
   logic [X_BITS-1:0]      w_r,      w_next_s;
   logic [Y_BITS-1:0]      h_r,      h_next_s;
   logic [B_BITS-1:0]      hb_r,     hb_next_s;
   logic [B_BITS-1:0]      vb_r,     vb_next_s;
   pattern_e               pat_r,    pat_next_s;
   logic [9:0]             fixed_r,  fixed_next_s;

   logic [X_BITS-1:0]      w_clamp_s;
   logic [Y_BITS-1:0]      h_clamp_s;
   logic [B_BITS-1:0]      hb_clamp_s;
   logic [B_BITS-1:0]      vb_clamp_s;
   logic                   capture_s;
   logic                   first_col_s, last_col_s, first_line_s, last_line_s;

   logic [9:0]             sync_s;
   logic [CHANNELS*10-1:0] data_s;
   logic [CHANNELS*10-1:0] pat_data_s;
   logic                   fs_s;
   logic                   busy_s;

   logic [9:0]             out_sync_r;
   logic [CHANNELS*10-1:0] out_data_r;
   logic                   out_fs_r;
   logic                   busy_r;

   assign w_clamp_s  = (bus.width < X_BITS'(2)) ? X_BITS'(2) : bus.width;
   assign h_clamp_s  = (bus.height == Y_BITS'(0)) ? Y_BITS'(1) : bus.height;
   assign hb_clamp_s = (bus.h_blank == B_BITS'(0)) ? B_BITS'(1) : bus.h_blank;
   assign vb_clamp_s = (bus.v_blank == B_BITS'(0)) ? B_BITS'(1) : bus.v_blank;

   assign first_col_s  = (x_r == X_BITS'(0));
   assign last_col_s   = (x_r == w_r - X_BITS'(1));
   assign first_line_s = (y_r == Y_BITS'(0));
   assign last_line_s  = (y_r == h_r - Y_BITS'(1));

   // Next-state, position counters and frame-start geometry capture.
   always_comb begin
      state_next_s = state_r;
      x_next_s     = x_r;
      y_next_s     = y_r;
      cnt_next_s   = cnt_r;
      w_next_s     = w_r;
      h_next_s     = h_r;
      hb_next_s    = hb_r;
      vb_next_s    = vb_r;
      pat_next_s   = pat_r;
      fixed_next_s = fixed_r;
      capture_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (bus.enable) begin
               state_next_s = ST_LINE;
               capture_s    = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LINE: begin
            if (last_col_s) begin
               x_next_s = X_BITS'(0);
               if (last_line_s) begin
                  state_next_s = ST_VBLANK;
                  cnt_next_s   = vb_r - B_BITS'(1);
               end else begin
                  state_next_s = ST_HBLANK;
                  cnt_next_s   = hb_r - B_BITS'(1);
               end
            end else begin
               x_next_s = x_r + X_BITS'(1);
            end
         end
         ST_HBLANK: begin
            if (cnt_r == B_BITS'(0)) begin
               state_next_s = ST_LINE;
               y_next_s     = y_r + Y_BITS'(1);
            end else begin
               cnt_next_s = cnt_r - B_BITS'(1);
            end
         end
         ST_VBLANK: begin
            if (cnt_r == B_BITS'(0)) begin
               if (bus.enable) begin
                  state_next_s = ST_LINE;
                  capture_s    = 1'b1;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               cnt_next_s = cnt_r - B_BITS'(1);
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase

      // The FS cycle runs on freshly sampled geometry, so later input changes
      // cannot disturb a frame in progress.
      if (capture_s) begin
         x_next_s     = X_BITS'(0);
         y_next_s     = Y_BITS'(0);
         w_next_s     = w_clamp_s;
         h_next_s     = h_clamp_s;
         hb_next_s    = hb_clamp_s;
         vb_next_s    = vb_clamp_s;
         pat_next_s   = pattern_e'(bus.pattern);
         fixed_next_s = bus.fixed_value;
      end else begin
         pat_next_s   = pat_r;
         fixed_next_s = fixed_r;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         x_r     <= X_BITS'(0);
         y_r     <= Y_BITS'(0);
         cnt_r   <= B_BITS'(0);
         w_r     <= X_BITS'(2);
         h_r     <= Y_BITS'(1);
         hb_r    <= B_BITS'(1);
         vb_r    <= B_BITS'(1);
         pat_r   <= PAT_RAMP;
         fixed_r <= 10'h000;
      end else if (cke) begin
         state_r <= state_next_s;
         x_r     <= x_next_s;
         y_r     <= y_next_s;
         cnt_r   <= cnt_next_s;
         w_r     <= w_next_s;
         h_r     <= h_next_s;
         hb_r    <= hb_next_s;
         vb_r    <= vb_next_s;
         pat_r   <= pat_next_s;
         fixed_r <= fixed_next_s;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      python_tx_pattern #(
         .CHANNELS (CHANNELS),
         .X_BITS   (X_BITS),
         .Y_BITS   (Y_BITS)
      ) u_pattern (
         .pattern     (pat_r),
         .x           (x_r),
         .y           (y_r),
         .channel     (10'(c)),
         .fixed_value (fixed_r),
         .word        (pat_data_s[c*10 +: 10])
      );
   end

   // Word selection for the current state; outside LINE the data lanes carry
   // the training word so the receiver can keep aligning.
   always_comb begin
      sync_s = SYNC_TR;
      data_s = {CHANNELS{TRAIN_WORD}};
      fs_s   = 1'b0;
      busy_s = (state_r != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            sync_s = SYNC_TR;
         end
         ST_LINE: begin
            sync_s = line_sync_code(first_col_s, last_col_s, first_line_s, last_line_s);
            data_s = pat_data_s;
            fs_s   = first_col_s & first_line_s;
         end
         ST_HBLANK, ST_VBLANK: begin
            sync_s = SYNC_BL;
         end
         default: begin
            sync_s = SYNC_TR;
         end
      endcase
   end

   // Output registers; reset forces training words at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_sync_r <= SYNC_TR;
         out_data_r <= {CHANNELS{TRAIN_WORD}};
         out_fs_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else if (cke) begin
         out_sync_r <= sync_s;
         out_data_r <= data_s;
         out_fs_r   <= fs_s;
         busy_r     <= busy_s;
      end
   end

   assign bus.out_sync        = out_sync_r;
   assign bus.out_data        = out_data_r;
   assign bus.out_frame_start = out_fs_r;
   assign bus.busy            = busy_r;

endmodule

// File: tb/tb_python_stream_gen_10bit.sv
// Directed bench for python_stream_gen_10bit: hand-computed sync sequences,
// pattern words, clamping, reset, cke stalls and back-to-back frames.
module tb_python_stream_gen_10bit;

   localparam int         CHANNELS = 4;
   localparam logic [9:0] TR  = 10'h3A6;
   localparam logic [9:0] FS  = 10'h2AA;
   localparam logic [9:0] FE  = 10'h3AA;
   localparam logic [9:0] LS  = 10'h0AA;
   localparam logic [9:0] LE  = 10'h12A;
   localparam logic [9:0] IMG = 10'h035;
   localparam logic [9:0] BL  = 10'h015;

   logic clk = 1'b0;
   logic reset;
   logic cke;
   int   check_cnt = 0;
   int   error_cnt = 0;
   int   fs_cnt;

   logic [9:0] seq_frame[17] = '{FS, IMG, IMG, LE, BL, BL, BL, LS, IMG, IMG, FE,
                                 BL, BL, BL, BL, BL, TR};
   logic [9:0] seq_clamp[4]  = '{FS, FE, BL, TR};
   logic [9:0] seq_b2b[15]   = '{FS, IMG, IMG, FE, BL, BL,
                                 FS, IMG, IMG, IMG, IMG, FE, BL, BL, TR};

   python_stream_gen_10bit_if #(.CHANNELS(CHANNELS), .X_BITS(10), .Y_BITS(10), .B_BITS(8)) bus_if ();

   python_stream_gen_10bit #(
      .CHANNELS (CHANNELS),
      .X_BITS   (10),
      .Y_BITS   (10),
      .B_BITS   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .cke   (cke),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) begin
         error_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] ch_word(input int c);
      return bus_if.out_data[c*10 +: 10];
   endfunction

   task automatic wait_idle(input string tag);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         tick();
         if (bus_if.out_sync == TR && bus_if.busy == 1'b0) found = 1'b1;
      end
      check_val(tag, found, 1'b1);
   endtask

   task automatic start(input int w, input int h, input int hb, input int vb, input int pat);
      bus_if.width   = 10'(w);
      bus_if.height  = 10'(h);
      bus_if.h_blank = 8'(hb);
      bus_if.v_blank = 8'(vb);
      bus_if.pattern = 2'(pat);
      bus_if.enable  = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] one;
      int         w;
      one                = 10'd1;
      reset              = 1'b1;
      cke                = 1'b1;
      bus_if.enable      = 1'b0;
      bus_if.width       = 10'd4;
      bus_if.height      = 10'd2;
      bus_if.h_blank     = 8'd3;
      bus_if.v_blank     = 8'd5;
      bus_if.pattern     = 2'd0;
      bus_if.fixed_value = 10'h000;

      // Reset and idle training
      repeat (3) tick();
      reset = 1'b0;
      repeat (20) tick();
      check_val("idle_sync", bus_if.out_sync, TR);
      for (int c = 0; c < CHANNELS; c++) check_val($sformatf("idle_data%0d", c), ch_word(c), TR);
      check_val("idle_busy", bus_if.busy, 1'b0);
      check_val("idle_fs", bus_if.out_frame_start, 1'b0);

      // Single 4x2 ramp frame, enable dropped after FS
      start(4, 2, 3, 5, 0);
      fs_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i == 0) bus_if.enable = 1'b0;
         check_val($sformatf("frame_sync[%0d]", i), bus_if.out_sync, seq_frame[i]);
         check_val($sformatf("frame_busy[%0d]", i), bus_if.busy, (i < 16));
         fs_cnt += int'(bus_if.out_frame_start);
         if (i == 0) begin
            check_val("ramp_l0c0_ch0", ch_word(0), 10'h000);
            check_val("ramp_l0c0_ch3", ch_word(3), 10'h003);
         end
         if (i == 3) check_val("ramp_l0c3_ch1", ch_word(1), 10'h00D);
         if (i == 5) check_val("hblank_data", ch_word(0), TR);
         if (i == 7) check_val("ramp_l1c0_ch0", ch_word(0), 10'h001);
         if (i == 10) check_val("ramp_l1c3_ch2", ch_word(2), 10'h00F);
      end
      check_val("fs_pulse_count", fs_cnt, 1);

      // All-zero geometry is clamped to 2x1 with single blank words
      start(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) bus_if.enable = 1'b0;
         check_val($sformatf("clamp_sync[%0d]", i), bus_if.out_sync, seq_clamp[i]);
      end

      // Back-to-back frames, width changed mid-frame
      start(4, 1, 1, 2, 0);
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i == 0) bus_if.width = 10'd6;
         if (i == 6) bus_if.enable = 1'b0;
         check_val($sformatf("b2b_sync[%0d]", i), bus_if.out_sync, seq_b2b[i]);
         check_val($sformatf("b2b_busy[%0d]", i), bus_if.busy, (i < 14));
         if (i == 6) check_val("b2b_fs2", bus_if.out_frame_start, 1'b1);
         if (i == 11) check_val("b2b_f2c5_ch0", ch_word(0), 10'h014);
      end

      // Reset during line 1 column 2
      start(4, 2, 1, 1, 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 5) check_val("rst_pre_ls", bus_if.out_sync, LS);
      end
      reset = 1'b1;
      tick();
      check_val("rst_sync", bus_if.out_sync, TR);
      check_val("rst_data0", ch_word(0), TR);
      check_val("rst_busy", bus_if.busy, 1'b0);
      check_val("rst_fs", bus_if.out_frame_start, 1'b0);
      reset = 1'b0;
      tick();
      check_val("rst_gap", bus_if.out_sync, TR);
      tick();
      check_val("rst_refs_sync", bus_if.out_sync, FS);
      check_val("rst_refs_pulse", bus_if.out_frame_start, 1'b1);
      bus_if.enable = 1'b0;
      wait_idle("rst_drain");

      // cke toggling with walking one: each word held two clocks
      start(12, 1, 1, 1, 3);
      cke = 1'b0;
      for (int k = 0; k < 27; k++) begin
         tick();
         if (k == 1) bus_if.enable = 1'b0;
         if (k == 0) begin
            check_val("cke_hold_tr", bus_if.out_sync, TR);
         end else begin
            w = (k - 1) / 2;
            if (w == 0)       check_val($sformatf("cke_sync[%0d]", k), bus_if.out_sync, FS);
            else if (w < 11)  check_val($sformatf("cke_sync[%0d]", k), bus_if.out_sync, IMG);
            else if (w == 11) check_val($sformatf("cke_sync[%0d]", k), bus_if.out_sync, FE);
            else              check_val($sformatf("cke_sync[%0d]", k), bus_if.out_sync, BL);
            if (w < 12) begin
               check_val($sformatf("walk_ch0[%0d]", k), ch_word(0), one << (w % 10));
               check_val($sformatf("walk_ch1[%0d]", k), ch_word(1), one << ((w + 1) % 10));
            end else begin
               check_val($sformatf("walk_blank[%0d]", k), ch_word(0), TR);
            end
            if (w == 9)  check_val("walk_ch0_col9", ch_word(0), 10'h200);
            if (w == 10) check_val("walk_ch0_col10", ch_word(0), 10'h001);
         end
         cke = ~cke;
      end
      cke = 1'b1;
      wait_idle("cke_drain");

      // Fixed value and channel id patterns
      bus_if.fixed_value = 10'h155;
      for (int p = 1; p < 3; p++) begin
         start(2, 1, 1, 1, p);
         tick();
         bus_if.enable = 1'b0;
         check_val($sformatf("pat%0d_sync", p), bus_if.out_sync, FS);
         for (int c = 0; c < CHANNELS; c++)
            check_val($sformatf("pat%0d_ch%0d", p, c), ch_word(c), (p == 1) ? 10'h155 : 10'(c));
         wait_idle($sformatf("pat%0d_drain", p));
      end

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
